// File: rtl/bpred_gshare.sv
// Gshare / bimodal conditional-branch predictor.
// Combinational predict path for decode; registered training, speculative global
// history with mispredict repair, and resolved-branch / mispredict counters.

`timescale 1ns/1ps

module bpred_gshare #(
  parameter int BHT_ADDR_BITS = 5,
  parameter int CNT_BITS      = 2,
  parameter int GHIST_BITS    = 5,
  parameter int GSHARE        = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  // predict (decode)
  input  logic                     i_p_valid,
  input  logic [31:0]              i_p_pc,
  output logic                     o_p_taken,
  output logic [BHT_ADDR_BITS-1:0] o_p_index,
  output logic [GHIST_BITS-1:0]    o_p_hist,
  // update (execute)
  input  logic                     i_u_valid,
  input  logic [BHT_ADDR_BITS-1:0] i_u_index,
  input  logic [GHIST_BITS-1:0]    i_u_hist,
  input  logic                     i_u_taken,
  input  logic                     i_u_mispredict,
  // performance counters
  output logic [31:0]              o_cnt_branch,
  output logic [31:0]              o_cnt_miss
);

  localparam int ENTRIES = 1 << BHT_ADDR_BITS;
  // Weakly not-taken; collapses to 0 for single-bit counters.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  logic [CNT_BITS-1:0]      r_bht [ENTRIES];
  logic [GHIST_BITS-1:0]    r_ghist;
  logic [31:0]              r_cnt_branch;
  logic [31:0]              r_cnt_miss;

  logic [BHT_ADDR_BITS-1:0] w_hist_ext;
  logic [BHT_ADDR_BITS-1:0] w_index;
  logic [CNT_BITS-1:0]      w_cnt_rd;
  logic [CNT_BITS-1:0]      w_cnt_upd;
  logic                     w_taken;
  logic [GHIST_BITS-1:0]    w_hist_repair;
  logic [GHIST_BITS-1:0]    w_hist_spec;
  logic                     w_unused_hist;
  logic                     w_unused;

  // Index formation and table read; no bypass from a same-cycle update.
  always_comb begin
    w_hist_ext                   = '0;
    w_hist_ext[GHIST_BITS-1:0]   = r_ghist;
    w_index                      = i_p_pc[BHT_ADDR_BITS+1:2] ^ ((GSHARE != 0) ? w_hist_ext : '0);
    w_cnt_rd                     = r_bht[w_index];
    w_taken                      = w_cnt_rd[CNT_BITS-1];
  end

  assign o_p_taken    = w_taken;
  assign o_p_index    = w_index;
  assign o_p_hist     = r_ghist;
  assign o_cnt_branch = r_cnt_branch;
  assign o_cnt_miss   = r_cnt_miss;

  // Next history values for repair and speculative shift (1-bit history is just the outcome).
  generate
    if (GHIST_BITS == 1) begin : g_hist1
      assign w_hist_repair = i_u_taken;
      assign w_hist_spec   = w_taken;
      assign w_unused_hist = i_u_hist[0];
    end else begin : g_histn
      assign w_hist_repair = {i_u_hist[GHIST_BITS-2:0], i_u_taken};
      assign w_hist_spec   = {r_ghist[GHIST_BITS-2:0], w_taken};
      assign w_unused_hist = i_u_hist[GHIST_BITS-1];
    end
  endgenerate

  assign w_unused = ^{i_p_pc[31:BHT_ADDR_BITS+2], i_p_pc[1:0], w_unused_hist};

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    w_cnt_upd = r_bht[i_u_index];
    if (i_u_taken) begin
      if (r_bht[i_u_index] != CNT_MAX) w_cnt_upd = r_bht[i_u_index] + CNT_ONE;
    end else begin
      if (r_bht[i_u_index] != CNT_ZERO) w_cnt_upd = r_bht[i_u_index] - CNT_ONE;
    end
  end

  // Counter table: reset to weakly not-taken, train on every resolved branch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) r_bht[i] <= CNT_INIT;
    end else if (i_u_valid) begin
      r_bht[i_u_index] <= w_cnt_upd;
    end
  end

  // Global history: a mispredict repair wins over a wrong-path speculative shift.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ghist <= '0;
    end else if (i_u_valid && i_u_mispredict) begin
      r_ghist <= w_hist_repair;
    end else if (i_p_valid) begin
      r_ghist <= w_hist_spec;
    end
  end

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt_branch <= '0;
      r_cnt_miss   <= '0;
    end else if (i_u_valid) begin
      r_cnt_branch <= r_cnt_branch + 32'd1;
      if (i_u_mispredict) r_cnt_miss <= r_cnt_miss + 32'd1;
    end
  end

endmodule
